// File: rtl/fft_pkg.sv
// Purpose: shared types and constants for the radix-2 DIT FFT stage sequencer.
// Contents: FFT size constants, address/twiddle index types, sequencer state encoding.
package fft_pkg;

  localparam int unsigned FFT_N_LOG2 = 8;
  localparam int unsigned FFT_N      = 1 << FFT_N_LOG2;
  localparam int unsigned STAGE_W    = 4;
  localparam int unsigned DRAIN_W    = 4;

  typedef logic [FFT_N_LOG2-1:0] fft_addr_t;
  typedef logic [FFT_N_LOG2-2:0] tw_idx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Purpose: combinational map from (stage, butterfly index j) to operand
//          addresses and twiddle ROM index for an in-place radix-2 DIT FFT.
// Ports:
//   stage    in   current stage, 0..N_LOG2-1
//   j        in   butterfly index within the stage, 0..N/2-1
//   addr_a   out  top operand address
//   addr_b   out  bottom operand address (addr_a | 2^stage)
//   tw_index out  twiddle ROM index, (j mod 2^stage) << (N_LOG2-1-stage)
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = FFT_N_LOG2
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [N_LOG2-2:0]  j,
  output logic [N_LOG2-1:0]  addr_a,
  output logic [N_LOG2-1:0]  addr_b,
  output logic [N_LOG2-2:0]  tw_index
);

  localparam int unsigned A_W = N_LOG2;

  logic [A_W-1:0]     j_w;
  logic [A_W-1:0]     h;
  logic [A_W-1:0]     k;
  logic [A_W-1:0]     hi;
  logic [STAGE_W-1:0] tw_sh;

  // Insert a zero bit at position 'stage' of j to form addr_a; set it for addr_b.
  always_comb begin
    j_w      = A_W'(j);
    h        = A_W'(1) << stage;
    k        = j_w & (h - A_W'(1));
    hi       = (j_w >> stage) << (stage + STAGE_W'(1));
    addr_a   = hi | k;
    addr_b   = addr_a | h;
    tw_sh    = STAGE_W'(N_LOG2 - 1) - stage;
    tw_index = (N_LOG2 - 1)'(k << tw_sh);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Purpose: stage/butterfly sequencer for an in-place radix-2 DIT FFT. Walks every
//          stage, issues butterfly operand addresses with a valid/ready handshake,
//          controls the twiddle-index counter and drains the butterfly pipeline
//          between stages.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 begin a transform (IDLE only)
//   abort                 synchronous cancel in any non-IDLE state
//   bfly_ready            datapath accepts the presented butterfly
//   bfly_valid            addr_a/addr_b/tw_index valid
//   addr_a, addr_b        operand addresses
//   tw_index              reference twiddle ROM index
//   stage_count           current stage to the twiddle-index counter
//   k_enable              twiddle counter advance (bfly_valid & bfly_ready)
//   k_clear               twiddle counter clear
//   busy                  high outside IDLE
//   done                  one-cycle completion pulse
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2     = FFT_N_LOG2,
  parameter int unsigned PIPE_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 bfly_ready,
  output logic                 bfly_valid,
  output logic [N_LOG2-1:0]    addr_a,
  output logic [N_LOG2-1:0]    addr_b,
  output logic [N_LOG2-2:0]    tw_index,
  output logic [STAGE_W-1:0]   stage_count,
  output logic                 k_enable,
  output logic                 k_clear,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned        J_W        = N_LOG2 - 1;
  localparam logic [J_W-1:0]     J_LAST     = {J_W{1'b1}};
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_DEPTH);

  seq_state_t           state, state_nxt;
  logic [J_W-1:0]       j, j_nxt;
  logic [STAGE_W-1:0]   stage, stage_nxt;
  logic [DRAIN_W-1:0]   drain_cnt, drain_nxt;
  logic                 xfer;
  logic [N_LOG2-1:0]    addr_a_nxt, addr_b_nxt;
  logic [N_LOG2-2:0]    tw_nxt;

  // Handshake: the only input-to-output path.
  assign xfer        = bfly_valid & bfly_ready;
  assign k_enable    = xfer;
  assign stage_count = stage;

  // Next-state and counter update.
  always_comb begin
    state_nxt = state;
    j_nxt     = j;
    stage_nxt = stage;
    drain_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
          stage_nxt = '0;
          j_nxt     = '0;
        end
      end
      CLEAR: begin
        j_nxt     = '0;
        state_nxt = RUN;
      end
      RUN: begin
        if (xfer) begin
          if (j == J_LAST) begin
            j_nxt     = '0;
            drain_nxt = DRAIN_INIT;
            state_nxt = DRAIN;
          end else begin
            j_nxt = j + J_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt <= DRAIN_W'(1)) begin
          drain_nxt = '0;
          if (stage == STAGE_LAST) begin
            state_nxt = DONE;
          end else begin
            stage_nxt = stage + STAGE_W'(1);
            state_nxt = CLEAR;
          end
        end else begin
          drain_nxt = drain_cnt - DRAIN_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Abort overrides everything except IDLE, where start takes priority.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      j_nxt     = '0;
      drain_nxt = '0;
    end
  end

  // Addresses for the butterfly that will be presented next cycle.
  fft_addr_gen #(
    .N_LOG2 (N_LOG2)
  ) u_addr_gen (
    .stage    (stage_nxt),
    .j        (j_nxt),
    .addr_a   (addr_a_nxt),
    .addr_b   (addr_b_nxt),
    .tw_index (tw_nxt)
  );

  // State register plus outputs registered from the next state, so each output
  // equals a decode of the current state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      j          <= '0;
      stage      <= '0;
      drain_cnt  <= '0;
      bfly_valid <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      tw_index   <= '0;
      k_clear    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      j          <= j_nxt;
      stage      <= stage_nxt;
      drain_cnt  <= drain_nxt;
      bfly_valid <= (state_nxt == RUN);
      addr_a     <= (state_nxt == RUN) ? addr_a_nxt : '0;
      addr_b     <= (state_nxt == RUN) ? addr_b_nxt : '0;
      tw_index   <= (state_nxt == RUN) ? tw_nxt : '0;
      k_clear    <= (state_nxt == IDLE) || (state_nxt == CLEAR);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Purpose: self-checking bench for fft_stage_sequencer. Expected butterfly
//          transfers are queued per transform and compared as the DUT issues them.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int NB       = 128;
  localparam int NSTAGE   = 8;
  localparam int EXP_LAT  = 1065;
  localparam int BUDGET   = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       bfly_ready;
  logic       bfly_valid;
  logic [7:0] addr_a;
  logic [7:0] addr_b;
  logic [6:0] tw_index;
  logic [3:0] stage_count;
  logic       k_enable;
  logic       k_clear;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  fft_stage_sequencer #(
    .N_LOG2     (8),
    .PIPE_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .bfly_ready  (bfly_ready),
    .bfly_valid  (bfly_valid),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .tw_index    (tw_index),
    .stage_count (stage_count),
    .k_enable    (k_enable),
    .k_clear     (k_clear),
    .busy        (busy),
    .done        (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference map, written as a = 2j - k rather than bit insertion.
  function automatic logic [27:0] model_xfer(input int s, input int jj);
    int h, k, a, b, tw;
    h  = 1 << s;
    k  = jj % h;
    a  = jj + (jj - k);
    b  = a + h;
    tw = k * (NB >> s);
    return {1'b1, 4'(s), 8'(a), 8'(b), 7'(tw)};
  endfunction

  logic [27:0] exp_q[$];
  int          xfer_total;
  int          done_cnt;
  int          per_stage[NSTAGE];
  logic [22:0] rec_first[NSTAGE];
  logic [22:0] rec_second[NSTAGE];
  logic [22:0] rec_last[NSTAGE];
  logic [22:0] rec_s3j9;

  task automatic begin_run();
    exp_q.delete();
    for (int s = 0; s < NSTAGE; s++)
      for (int jj = 0; jj < NB; jj++)
        exp_q.push_back(model_xfer(s, jj));
    xfer_total = 0;
    done_cnt   = 0;
    rec_s3j9   = '0;
    for (int s = 0; s < NSTAGE; s++) begin
      per_stage[s]  = 0;
      rec_first[s]  = '0;
      rec_second[s] = '0;
      rec_last[s]   = '0;
    end
  endtask

  // Scoreboard: pop and compare each accepted butterfly.
  task automatic observe();
    logic [27:0] got;
    logic [27:0] exp;
    int          s;
    int          idx;
    if (bfly_valid && bfly_ready) begin
      got = {k_enable, stage_count, addr_a, addr_b, tw_index};
      if (exp_q.size() == 0) begin
        check_eq("xfer_unexpected", 32'(got), 32'hFFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        check_eq("xfer", 32'(got), 32'(exp));
      end
      xfer_total++;
      s = int'(stage_count);
      if (s < NSTAGE) begin
        idx = per_stage[s];
        if (idx == 0)      rec_first[s]  = {addr_a, addr_b, tw_index};
        if (idx == 1)      rec_second[s] = {addr_a, addr_b, tw_index};
        if (idx == NB - 1) rec_last[s]   = {addr_a, addr_b, tw_index};
        if (s == 3 && idx == 9) rec_s3j9 = {addr_a, addr_b, tw_index};
        per_stage[s] = idx + 1;
      end
    end
    if (done) done_cnt++;
  endtask

  // One clock: sample at negedge, then return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic check_full_run_totals(input string pfx);
    check_eq({pfx, "_xfer_total"}, 32'(xfer_total), 32'd1024);
    check_eq({pfx, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check_eq({pfx, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  n;
    bit  hit;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    bfly_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {bfly_valid, k_enable, k_clear, busy, done}, 5'b00100);
    check_eq("rst_addr", {addr_a, addr_b, tw_index, stage_count}, '0);
    rst = 1'b0;
    step();
    check_eq("idle_ctrl", {bfly_valid, k_clear, busy, done}, 4'b0100);

    // Full transform, ready held high.
    begin_run();
    bfly_ready = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < BUDGET) begin
      step();
      n++;
    end
    // done is captured by the edge after the one that raised it.
    check_eq("done_latency", 32'(n + 1), 32'(EXP_LAT));
    check_eq("busy_at_done", {busy, done}, 2'b11);
    step();
    check_eq("after_done", {busy, done, k_clear, bfly_valid}, 4'b0010);
    check_eq("stage_hold", 32'(stage_count), 32'd7);
    repeat (3) step();
    check_full_run_totals("runA");
    for (int s = 0; s < NSTAGE; s++)
      check_eq($sformatf("stage%0d_xfers", s), 32'(per_stage[s]), 32'd128);
    check_eq("s0_first",  32'(rec_first[0]),  32'({8'd0,   8'd1,   7'd0}));
    check_eq("s0_second", 32'(rec_second[0]), 32'({8'd2,   8'd3,   7'd0}));
    check_eq("s0_last",   32'(rec_last[0]),   32'({8'd254, 8'd255, 7'd0}));
    check_eq("s7_first",  32'(rec_first[7]),  32'({8'd0,   8'd128, 7'd0}));
    check_eq("s7_second", 32'(rec_second[7]), 32'({8'd1,   8'd129, 7'd1}));
    check_eq("s7_last",   32'(rec_last[7]),   32'({8'd127, 8'd255, 7'd127}));
    // k = 9 mod 8 = 1, shifted by 7-3.
    check_eq("s3_j9",     32'(rec_s3j9),      32'({8'd17,  8'd25,  7'd16}));

    // start with abort in IDLE: start wins.
    begin_run();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort_idle", {busy, k_clear, bfly_valid, stage_count}, 7'b1100000);

    // Stall at stage 2, j=40: wait until j=39 is presented, let it transfer.
    n = 0;
    hit = 1'b0;
    while (!hit && n < BUDGET) begin
      hit = bfly_valid && (stage_count == 4'd2) && (addr_a == 8'd75);
      if (!hit) begin
        step();
        n++;
      end
    end
    check_eq("reach_s2_j39", 32'(hit), 32'd1);
    step();
    bfly_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      observe();
      check_eq("stall_hold", {bfly_valid, k_enable, addr_a, addr_b}, {1'b1, 1'b0, 8'd80, 8'd84});
      @(posedge clk);
      #1;
    end
    bfly_ready = 1'b1;
    check_eq("stall_stage2_count", 32'(per_stage[2]), 32'd40);

    // Abort at stage 4, j=60; the j=60 transfer still happens.
    n = 0;
    hit = 1'b0;
    while (!hit && n < BUDGET) begin
      hit = bfly_valid && (stage_count == 4'd4) && (addr_a == 8'd107);
      if (!hit) begin
        step();
        n++;
      end
    end
    check_eq("reach_s4_j59", 32'(hit), 32'd1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_idle", {busy, k_clear, bfly_valid, done}, 4'b0100);
    check_eq("abort_stage4_xfers", 32'(per_stage[4]), 32'd61);
    repeat (5) step();
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);
    check_eq("abort_stays_idle", {busy, bfly_valid}, 2'b00);

    // Restart after abort, with a start pulse while busy that must be ignored.
    begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("restart_first", {bfly_valid, stage_count, addr_a, addr_b}, {1'b1, 4'd0, 8'd0, 8'd1});
    n = 1;
    while (!done && n < BUDGET) begin
      start = (n == 200);
      step();
      n++;
    end
    start = 1'b0;
    check_eq("runC_done_latency", 32'(n + 1), 32'(EXP_LAT));
    repeat (4) step();
    check_full_run_totals("runC");

    // Reset asserted during the stage 0 drain.
    begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(busy && !bfly_valid && per_stage[0] == NB) && n < BUDGET) begin
      step();
      n++;
    end
    check_eq("reach_drain", {busy, bfly_valid, 8'(per_stage[0])}, {1'b1, 1'b0, 8'd128});
    step();
    rst = 1'b1;
    #1;
    check_eq("rst_async_ctrl", {bfly_valid, k_enable, k_clear, busy, done}, 5'b00100);
    check_eq("rst_async_addr", {addr_a, addr_b, tw_index, stage_count}, '0);
    step();
    rst = 1'b0;
    repeat (8) step();
    check_eq("rst_no_done", 32'(done_cnt), 32'd0);
    check_eq("rst_idle", {busy, bfly_valid, k_clear}, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
